pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_if.sv | 27 ++
 rtl/pipe_stage_reg.sv | 128 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Fetch-to-decode pipeline stage bus: upstream offer, downstream hand-off,
// flush and occupancy. The master side drives the stage, and the slave side is the stage.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] ins_i;
  logic [ADDR_W-1:0] ins_addr_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] ins_o;
  logic [ADDR_W-1:0] ins_addr_o;
  logic [1:0]        occ_o;

  modport master (
    output flush_i, in_valid_i, ins_i, ins_addr_i, out_ready_i,
    input  in_ready_o, out_valid_o, ins_o, ins_addr_o, occ_o
  );

  modport slave (
    input  flush_i, in_valid_i, ins_i, ins_addr_i, out_ready_i,
    output in_ready_o, out_valid_o, ins_o, ins_addr_o, occ_o
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Fetch-to-decode pipeline register with optional one-entry skid buffer.
// Build option: define PIPE_SKID_EN to build the two-entry skid version.
// In that version, in_ready_o is decoded from state only.
// Without PIPE_SKID_EN, the stage holds one entry.
// In that version, in_ready_o passes out_ready_i through combinationally.
//
// state | meaning
// EMPTY | no entry held; outputs show NOP_INS / RESET_ADDR
// ONE   | main register valid and presented downstream
// FULL  | main and skid registers valid; skid holds the younger entry
module pipe_stage_reg #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter logic [DATA_W-1:0] NOP_INS    = 32'h0000_0013,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input logic           clk,
  input logic           rst,
  pipe_stage_reg_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_ins_q, main_ins_d;
  logic [ADDR_W-1:0] main_addr_q, main_addr_d;
`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skid_ins_q, skid_ins_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
`endif

  logic out_vld;
  logic in_rdy;
  logic in_xfer;
  logic out_xfer;

  // State and data registers; reset empties the stage immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ins_q  <= NOP_INS;
      main_addr_q <= RESET_ADDR;
`ifdef PIPE_SKID_EN
      skid_ins_q  <= NOP_INS;
      skid_addr_q <= RESET_ADDR;
`endif
    end else begin
      state_q     <= state_d;
      main_ins_q  <= main_ins_d;
      main_addr_q <= main_addr_d;
`ifdef PIPE_SKID_EN
      skid_ins_q  <= skid_ins_d;
      skid_addr_q <= skid_addr_d;
`endif
    end
  end

  // Next state and data: FIFO order is main then skid, and flush wins over everything.
  always_comb begin
    state_d     = state_q;
    main_ins_d  = main_ins_q;
    main_addr_d = main_addr_q;
`ifdef PIPE_SKID_EN
    skid_ins_d  = skid_ins_q;
    skid_addr_d = skid_addr_q;
`endif
    in_xfer  = bus.in_valid_i && in_rdy;
    out_xfer = out_vld && bus.out_ready_i;

    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d     = ONE;
          main_ins_d  = bus.ins_i;
          main_addr_d = bus.ins_addr_i;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_ins_d  = bus.ins_i;
          main_addr_d = bus.ins_addr_i;
`ifdef PIPE_SKID_EN
        end else if (in_xfer) begin
          state_d     = FULL;
          skid_ins_d  = bus.ins_i;
          skid_addr_d = bus.ins_addr_i;
`endif
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
`ifdef PIPE_SKID_EN
      FULL: begin
        if (out_xfer) begin
          state_d     = ONE;
          main_ins_d  = skid_ins_q;
          main_addr_d = skid_addr_q;
        end
      end
`endif
      default: state_d = EMPTY;
    endcase

    if (bus.flush_i) begin
      state_d = EMPTY;
    end
  end

  // Outputs: handshake flags from state, and data taken from the main register only.
  always_comb begin
    out_vld = (state_q != EMPTY);
`ifdef PIPE_SKID_EN
    in_rdy  = (state_q != FULL);
`else
    in_rdy  = !out_vld || bus.out_ready_i;
`endif
    bus.out_valid_o = out_vld;
    bus.in_ready_o  = in_rdy;
    bus.occ_o       = 2'(state_q);
    bus.ins_o       = out_vld ? main_ins_q  : NOP_INS;
    bus.ins_addr_o  = out_vld ? main_addr_q : RESET_ADDR;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. It covers the default build, and the PIPE_SKID_EN build when that macro is defined.
module tb_pipe_stage_reg;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pipe_stage_reg_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  pipe_stage_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] ins, input logic [31:0] addr);
    bus.in_valid_i = v;
    bus.ins_i      = ins;
    bus.ins_addr_i = addr;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid_o), 32'd0);
    chk({tag, "_occ"},   32'(bus.occ_o),       32'd0);
    chk({tag, "_ins"},   bus.ins_o,            NOP);
    chk({tag, "_addr"},  bus.ins_addr_o,       32'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.flush_i = 1'b0;
    bus.out_ready_i = 1'b0;
    offer(1'b0, 32'h0, 32'h0);

    // Checks held-in-reset values.
    #3;
    chk_empty("rst");
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    step();
    step();
    rst = 1'b0;

    // First instruction arrives after one edge.
    bus.out_ready_i = 1'b1;
    offer(1'b1, 32'h0050_0093, 32'h0);
    step();
    offer(1'b0, 32'h0, 32'h0);
    chk("first_valid", 32'(bus.out_valid_o), 32'd1);
    chk("first_ins",   bus.ins_o,            32'h0050_0093);
    chk("first_addr",  bus.ins_addr_o,       32'h0);
    chk("first_occ",   32'(bus.occ_o),       32'd1);
    step();
    chk_empty("drain1");

    // Back-to-back offers while downstream is stalled.
    bus.out_ready_i = 1'b0;
    offer(1'b1, 32'h11, 32'h0);
    step();
    chk("bb_occ1", 32'(bus.occ_o), 32'd1);
    chk("bb_ins1", bus.ins_o,      32'h11);
    offer(1'b1, 32'h22, 32'h4);
`ifdef PIPE_SKID_EN
    chk("bb_rdy1", 32'(bus.in_ready_o), 32'd1);
    step();
    offer(1'b1, 32'h33, 32'h8);
    chk("bb_occ2", 32'(bus.occ_o),      32'd2);
    chk("bb_rdy2", 32'(bus.in_ready_o), 32'd0);
    step();
    chk("bb_hold_occ", 32'(bus.occ_o), 32'd2);
    chk("bb_hold_ins", bus.ins_o,      32'h11);
    bus.out_ready_i = 1'b1;
    #1;
    chk("bb_rdy_reg", 32'(bus.in_ready_o), 32'd0);
    step();
    chk("bb_out_22",   bus.ins_o,      32'h22);
    chk("bb_out_22a",  bus.ins_addr_o, 32'h4);
    chk("bb_occ_back", 32'(bus.occ_o), 32'd1);
    step();
    offer(1'b0, 32'h0, 32'h0);
    chk("bb_out_33",  bus.ins_o,      32'h33);
    chk("bb_out_33a", bus.ins_addr_o, 32'h8);
    step();
    chk_empty("bb_drain");
`else
    chk("bb_rdy_stall", 32'(bus.in_ready_o), 32'd0);
    step();
    chk("bb_hold_occ",  32'(bus.occ_o),  32'd1);
    chk("bb_hold_ins",  bus.ins_o,       32'h11);
    chk("bb_hold_addr", bus.ins_addr_o,  32'h0);
    bus.out_ready_i = 1'b1;
    #1;
    chk("bb_rdy_follow", 32'(bus.in_ready_o), 32'd1);
    step();
    chk("bb_out_22",  bus.ins_o,      32'h22);
    chk("bb_out_22a", bus.ins_addr_o, 32'h4);
    chk("bb_occ_max", 32'(bus.occ_o), 32'd1);
    offer(1'b1, 32'h33, 32'h8);
    step();
    offer(1'b0, 32'h0, 32'h0);
    chk("bb_out_33",  bus.ins_o,      32'h33);
    chk("bb_out_33a", bus.ins_addr_o, 32'h8);
    step();
    chk_empty("bb_drain");
`endif

    // Simultaneous in and out transfers keep occupancy at one.
    bus.out_ready_i = 1'b0;
    offer(1'b1, 32'hA0, 32'h100);
    step();
    bus.out_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      offer(1'b1, 32'hA0 + 32'(i), 32'h100 + 32'(4 * i));
      step();
      chk("stream_ins",  bus.ins_o,      32'hA0 + 32'(i));
      chk("stream_addr", bus.ins_addr_o, 32'h100 + 32'(4 * i));
      chk("stream_occ",  32'(bus.occ_o), 32'd1);
    end
    offer(1'b0, 32'h0, 32'h0);
    step();
    chk_empty("stream_drain");

    // Flush with a simultaneous offer drops everything.
    bus.out_ready_i = 1'b0;
    offer(1'b1, 32'h11, 32'h0);
    step();
`ifdef PIPE_SKID_EN
    offer(1'b1, 32'h22, 32'h4);
    step();
    chk("fl_pre_occ", 32'(bus.occ_o), 32'd2);
`else
    chk("fl_pre_occ", 32'(bus.occ_o), 32'd1);
`endif
    bus.flush_i = 1'b1;
    offer(1'b1, 32'h44, 32'hC);
    step();
    bus.flush_i = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    chk_empty("flush");
    chk("flush_rdy", 32'(bus.in_ready_o), 32'd1);
    bus.out_ready_i = 1'b1;
    step();
    chk_empty("flush_no44");

    // Asynchronous reset between edges empties the stage at once.
    bus.out_ready_i = 1'b0;
    offer(1'b1, 32'h55, 32'h10);
    step();
`ifdef PIPE_SKID_EN
    offer(1'b1, 32'h66, 32'h14);
    step();
`endif
    offer(1'b0, 32'h0, 32'h0);
    chk("ar_pre_valid", 32'(bus.out_valid_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_empty("async_rst");
    #1;
    rst = 1'b0;
    step();
    chk_empty("post_rst");
    chk("post_rst_rdy", 32'(bus.in_ready_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
